// File: rtl/snitch_fp_sb_if.sv
// Issue / commit / status bundle of the FP register scoreboard.
// The slave modport is the scoreboard side; the master modport is the issuing core.
interface snitch_fp_sb_if #(
  parameter int unsigned NrRegs        = 32,
  parameter int unsigned NrReadPorts   = 3,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned CntWidth      = 2
);
  localparam int unsigned AddrWidth = $clog2(NrRegs);
  localparam int unsigned OutWidth  = $clog2(NrRegs * (2**CntWidth - 1) + 1);

  logic                                     issue_valid_i;
  logic                                     issue_ready_o;
  logic [AddrWidth-1:0]                     issue_rd_i;
  logic                                     issue_rd_is_fp_i;
  logic [NrReadPorts-1:0][AddrWidth-1:0]    issue_rs_i;
  logic [NrReadPorts-1:0]                   issue_rs_used_i;
  logic [NrCommitPorts-1:0]                 commit_valid_i;
  logic [NrCommitPorts-1:0][AddrWidth-1:0]  commit_rd_i;
  logic                                     flush_i;
  logic                                     busy_o;
  logic [OutWidth-1:0]                      outstanding_o;
  logic                                     stall_raw_o;
  logic                                     stall_waw_o;
  logic                                     underflow_o;

  modport slave (
    input  issue_valid_i, issue_rd_i, issue_rd_is_fp_i, issue_rs_i, issue_rs_used_i,
    input  commit_valid_i, commit_rd_i, flush_i,
    output issue_ready_o, busy_o, outstanding_o, stall_raw_o, stall_waw_o, underflow_o
  );

  modport master (
    output issue_valid_i, issue_rd_i, issue_rd_is_fp_i, issue_rs_i, issue_rs_used_i,
    output commit_valid_i, commit_rd_i, flush_i,
    input  issue_ready_o, busy_o, outstanding_o, stall_raw_o, stall_waw_o, underflow_o
  );
endinterface

// File: rtl/snitch_fp_scoreboard.sv
// Per-register pending-write scoreboard gating FP instruction issue on RAW/WAW hazards.
// Define SNITCH_FP_SB_BYPASS_EN to let a same-cycle commit release a source with count 1.
module snitch_fp_scoreboard #(
  parameter int unsigned NrRegs        = 32,
  parameter int unsigned NrReadPorts   = 3,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned CntWidth      = 2,
  parameter bit          StrictWaw     = 1'b1
) (
  input logic            clk_i,
  input logic            rst_i,
  snitch_fp_sb_if.slave  sb
);
  localparam int unsigned AddrWidth = $clog2(NrRegs);
  localparam int unsigned OutWidth  = $clog2(NrRegs * (2**CntWidth - 1) + 1);
  localparam int unsigned CalcWidth = CntWidth + NrCommitPorts + 1;
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [CntWidth-1:0]    r_cnt [NrRegs];
  logic [CntWidth-1:0]    w_cnt_next [NrRegs];
  logic [NrRegs-1:0]      w_uf_hit;
  logic [OutWidth-1:0]    r_outstanding;
  logic [OutWidth-1:0]    w_outstanding_next;
  logic                   r_underflow;
  logic [NrReadPorts-1:0] w_src_pending;
  logic                   w_dst_block;
  logic                   w_ready;
  logic                   w_fire;

  genvar gi;

  for (gi = 0; gi < NrReadPorts; gi++) begin : g_src
    logic [AddrWidth-1:0] w_rs;
    logic                 w_bypass;
    assign w_rs = sb.issue_rs_i[gi];
`ifdef SNITCH_FP_SB_BYPASS_EN
    always_comb begin
      w_bypass = 1'b0;
      for (int p = 0; p < NrCommitPorts; p++) begin
        if (sb.commit_valid_i[p] && (sb.commit_rd_i[p] == w_rs) &&
            (r_cnt[w_rs] == CntWidth'(1)))
          w_bypass = 1'b1;
      end
    end
`else
    assign w_bypass = 1'b0;
`endif
    assign w_src_pending[gi] = sb.issue_rs_used_i[gi] && (r_cnt[w_rs] != '0) && !w_bypass;
  end

  assign w_dst_block = sb.issue_rd_is_fp_i &&
                       (StrictWaw ? (r_cnt[sb.issue_rd_i] != '0)
                                  : (r_cnt[sb.issue_rd_i] == CntMax));
  assign w_ready = !(|w_src_pending) && !w_dst_block && !sb.flush_i;
  assign w_fire  = sb.issue_valid_i && w_ready;

  // Over-committing clamps at zero and raises the sticky underflow flag.
  for (gi = 0; gi < NrRegs; gi++) begin : g_reg
    logic [CalcWidth-1:0] w_total;
    logic [CalcWidth-1:0] w_hits;
    logic [CntWidth-1:0]  w_next;
    logic                 w_uf;
    always_comb begin
      w_hits = '0;
      for (int p = 0; p < NrCommitPorts; p++) begin
        if (sb.commit_valid_i[p] && (sb.commit_rd_i[p] == AddrWidth'(gi)))
          w_hits = w_hits + CalcWidth'(1);
      end
      w_total = CalcWidth'(r_cnt[gi]) +
                CalcWidth'(w_fire && sb.issue_rd_is_fp_i && (sb.issue_rd_i == AddrWidth'(gi)));
      if (w_hits > w_total) begin
        w_next = '0;
        w_uf   = 1'b1;
      end else begin
        w_next = CntWidth'(w_total - w_hits);
        w_uf   = 1'b0;
      end
    end
    assign w_cnt_next[gi] = w_next;
    assign w_uf_hit[gi]   = w_uf;
  end

  always_comb begin
    w_outstanding_next = '0;
    for (int r = 0; r < NrRegs; r++)
      w_outstanding_next = w_outstanding_next + OutWidth'(w_cnt_next[r]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NrRegs; r++) r_cnt[r] <= '0;
      r_outstanding <= '0;
      r_underflow   <= 1'b0;
    end else if (sb.flush_i) begin
      for (int r = 0; r < NrRegs; r++) r_cnt[r] <= '0;
      r_outstanding <= '0;
    end else begin
      for (int r = 0; r < NrRegs; r++) r_cnt[r] <= w_cnt_next[r];
      r_outstanding <= w_outstanding_next;
      if (|w_uf_hit) r_underflow <= 1'b1;
    end
  end

  assign sb.issue_ready_o = w_ready;
  assign sb.stall_raw_o   = sb.issue_valid_i && (|w_src_pending);
  assign sb.stall_waw_o   = sb.issue_valid_i && w_dst_block;
  assign sb.outstanding_o = r_outstanding;
  assign sb.busy_o        = (r_outstanding != '0);
  assign sb.underflow_o   = r_underflow;
endmodule

// File: tb/tb_snitch_fp_scoreboard.sv
// Bench for snitch_fp_scoreboard: strict (StrictWaw=1) and relaxed (StrictWaw=0) instances
// share one stimulus stream and are checked against a count-per-register reference model.
module tb_snitch_fp_scoreboard;
  localparam int NR = 32, NRP = 3, NCP = 2, CW = 2, AW = 5, OW = 7;
  localparam int CMAX = 3;
`ifdef SNITCH_FP_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    t_valid, t_fp, t_flush;
  logic [AW-1:0]           t_rd;
  logic [NRP-1:0][AW-1:0]  t_rs;
  logic [NRP-1:0]          t_used;
  logic [NCP-1:0]          t_cv;
  logic [NCP-1:0][AW-1:0]  t_cr;

  snitch_fp_sb_if #(.NrRegs(NR), .NrReadPorts(NRP), .NrCommitPorts(NCP), .CntWidth(CW)) sb_s ();
  snitch_fp_sb_if #(.NrRegs(NR), .NrReadPorts(NRP), .NrCommitPorts(NCP), .CntWidth(CW)) sb_w ();

  snitch_fp_scoreboard #(.NrRegs(NR), .NrReadPorts(NRP), .NrCommitPorts(NCP), .CntWidth(CW),
                         .StrictWaw(1'b1)) dut_s (.clk_i(clk), .rst_i(rst), .sb(sb_s.slave));
  snitch_fp_scoreboard #(.NrRegs(NR), .NrReadPorts(NRP), .NrCommitPorts(NCP), .CntWidth(CW),
                         .StrictWaw(1'b0)) dut_w (.clk_i(clk), .rst_i(rst), .sb(sb_w.slave));

  assign sb_s.issue_valid_i = t_valid;      assign sb_w.issue_valid_i = t_valid;
  assign sb_s.issue_rd_i = t_rd;            assign sb_w.issue_rd_i = t_rd;
  assign sb_s.issue_rd_is_fp_i = t_fp;      assign sb_w.issue_rd_is_fp_i = t_fp;
  assign sb_s.issue_rs_i = t_rs;            assign sb_w.issue_rs_i = t_rs;
  assign sb_s.issue_rs_used_i = t_used;     assign sb_w.issue_rs_used_i = t_used;
  assign sb_s.commit_valid_i = t_cv;        assign sb_w.commit_valid_i = t_cv;
  assign sb_s.commit_rd_i = t_cr;           assign sb_w.commit_rd_i = t_cr;
  assign sb_s.flush_i = t_flush;            assign sb_w.flush_i = t_flush;

  logic          o_ready [2], o_raw [2], o_waw [2], o_busy [2], o_uf [2];
  logic [OW-1:0] o_out [2];
  assign o_ready[0] = sb_s.issue_ready_o;   assign o_ready[1] = sb_w.issue_ready_o;
  assign o_raw[0]   = sb_s.stall_raw_o;     assign o_raw[1]   = sb_w.stall_raw_o;
  assign o_waw[0]   = sb_s.stall_waw_o;     assign o_waw[1]   = sb_w.stall_waw_o;
  assign o_busy[0]  = sb_s.busy_o;          assign o_busy[1]  = sb_w.busy_o;
  assign o_uf[0]    = sb_s.underflow_o;     assign o_uf[1]    = sb_w.underflow_o;
  assign o_out[0]   = sb_s.outstanding_o;   assign o_out[1]   = sb_w.outstanding_o;

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt [2][NR];
  bit m_uf [2];
  bit m_rdy [2];

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_src_pend(int k, int i);
    int r = int'(t_rs[i]);
    if (!t_used[i] || m_cnt[k][r] == 0) return 1'b0;
    if (BYP && m_cnt[k][r] == 1)
      for (int p = 0; p < NCP; p++)
        if (t_cv[p] && int'(t_cr[p]) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_raw(int k);
    bit any = 1'b0;
    for (int i = 0; i < NRP; i++) any |= m_src_pend(k, i);
    return any;
  endfunction

  function automatic bit m_dst(int k);
    int c = m_cnt[k][int'(t_rd)];
    if (!t_fp) return 1'b0;
    return (k == 0) ? (c != 0) : (c == CMAX);
  endfunction

  function automatic int m_sum(int k);
    int s = 0;
    for (int r = 0; r < NR; r++) s += m_cnt[k][r];
    return s;
  endfunction

  task automatic set_in(bit v, bit fp, int rd, int rs0, int rs1, int rs2, bit [2:0] used,
                        bit [1:0] cv, int cr0, int cr1, bit fl);
    t_valid = v; t_fp = fp; t_rd = AW'(rd);
    t_rs[0] = AW'(rs0); t_rs[1] = AW'(rs1); t_rs[2] = AW'(rs2); t_used = used;
    t_cv = cv; t_cr[0] = AW'(cr0); t_cr[1] = AW'(cr1); t_flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0);
  endtask

  // One clock: check combinational and registered outputs mid-cycle, then advance the model.
  task automatic cycle(string tag);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      string nm = $sformatf("%s/%s", tag, (k == 0) ? "strict" : "relaxed");
      bit raw = m_raw(k);
      bit dst = m_dst(k);
      m_rdy[k] = !raw && !dst && !t_flush;
      chk({nm, "/ready"}, int'(o_ready[k]), int'(m_rdy[k]));
      chk({nm, "/stall_raw"}, int'(o_raw[k]), int'(t_valid && raw));
      chk({nm, "/stall_waw"}, int'(o_waw[k]), int'(t_valid && dst));
      chk({nm, "/outstanding"}, int'(o_out[k]), m_sum(k));
      chk({nm, "/busy"}, int'(o_busy[k]), int'(m_sum(k) != 0));
      chk({nm, "/underflow"}, int'(o_uf[k]), int'(m_uf[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit fire = t_valid && m_rdy[k];
      for (int r = 0; r < NR; r++) begin
        int hits = 0;
        int total = m_cnt[k][r] + ((fire && t_fp && int'(t_rd) == r) ? 1 : 0);
        for (int p = 0; p < NCP; p++) if (t_cv[p] && int'(t_cr[p]) == r) hits++;
        if (t_flush) m_cnt[k][r] = 0;
        else if (hits > total) begin m_cnt[k][r] = 0; m_uf[k] = 1'b1; end
        else m_cnt[k][r] = total - hits;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_uf[k] = 1'b0;
      for (int r = 0; r < NR; r++) m_cnt[k][r] = 0;
    end
  endtask

  initial begin
    model_reset();
    idle();
    // Reset phase: outputs cleared and ready follows all-zero counts.
    repeat (2) @(negedge clk);
    set_in(1, 1, 5, 1, 2, 3, 3'b111, 2'b00, 0, 0, 0);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst/ready%0d", k), int'(o_ready[k]), 1);
      chk($sformatf("rst/out%0d", k), int'(o_out[k]), 0);
      chk($sformatf("rst/busy%0d", k), int'(o_busy[k]), 0);
      chk($sformatf("rst/uf%0d", k), int'(o_uf[k]), 0);
    end
    idle();
    rst = 1'b0;
    @(posedge clk); #1;

    // First issue, then observe count of 1.
    set_in(1, 1, 5, 1, 2, 3, 3'b111, 2'b00, 0, 0, 0); cycle("issue5");
    idle(); cycle("after5");
    chk("after5/out_direct", int'(o_out[1]), 1);

    // Same-cycle commit vs source read on r5.
    set_in(1, 1, 5, 5, 0, 0, 3'b001, 2'b01, 5, 0, 0); cycle("bypass");
    set_in(1, 1, 5, 5, 0, 0, 3'b001, 2'b00, 0, 0, 0); cycle("bypass_next");
    idle(); cycle("bypass_idle");

    // Saturation of rd=7 and resumption after a commit.
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1); cycle("flush_a");
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 7, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle($sformatf("sat7_%0d", i));
    end
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 2'b01, 7, 0, 0); cycle("commit7");
    set_in(1, 1, 7, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle("resume7");

    // Dual commit to r9, then over-commit.
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1); cycle("flush_b");
    set_in(1, 1, 9, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle("iss9a");
    set_in(1, 1, 9, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle("iss9b");
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 9, 9, 0); cycle("dual9");
    idle(); cycle("dual9_idle");
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 2'b01, 9, 0, 0); cycle("over9");
    idle(); cycle("over9_idle");

    // Flush overriding issue and commit.
    set_in(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle("pf1");
    set_in(1, 1, 2, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle("pf2");
    set_in(1, 1, 3, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle("pf3");
    set_in(1, 1, 4, 0, 0, 0, 3'b000, 2'b01, 1, 0, 1); cycle("flush_c");
    idle(); cycle("flush_c_idle");

    // Randomized traffic on a small register window so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             3'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 19) == 0);
      cycle($sformatf("rand%0d", n));
    end

    // Asynchronous reset between edges.
    set_in(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1); cycle("flush_d");
    set_in(1, 1, 4, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0); cycle("iss4");
    idle();
    chk("pre_async/out", int'(o_out[0]), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async/out%0d", k), int'(o_out[k]), 0);
      chk($sformatf("async/busy%0d", k), int'(o_busy[k]), 0);
      chk($sformatf("async/uf%0d", k), int'(o_uf[k]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    idle(); cycle("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
